// File: rtl/asm_check_monitor.sv
// Self-check monitor: shadows register-file writebacks and retires a table of
// flag-triggered register checks in order, reporting pass, fail or timeout.
module asm_check_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_CHECKS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned FLAG_REG       = 20,
  localparam int unsigned IdxW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            cfg_we,
  input  logic [IdxW-1:0] cfg_idx,
  input  logic [XLEN-1:0] cfg_flag,
  input  logic [4:0]      cfg_reg,
  input  logic [XLEN-1:0] cfg_expected,
  input  logic [IdxW:0]   cfg_count,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [IdxW-1:0] fail_idx,
  output logic [XLEN-1:0] fail_got
);

  localparam logic [4:0] FlagAddr = 5'(FLAG_REG);

  typedef enum logic [2:0] {StIdle, StWait, StPass, StFail, StTimeout} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] shadow_q   [32];
  logic [XLEN-1:0] tbl_flag_q [NUM_CHECKS];
  logic [XLEN-1:0] tbl_exp_q  [NUM_CHECKS];
  logic [4:0]      tbl_reg_q  [NUM_CHECKS];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW:0]   count_q, count_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [IdxW-1:0] fail_idx_d;
  logic [XLEN-1:0] fail_got_d;

  logic [XLEN-1:0] cur_flag, cur_val;
  logic            flag_hit, val_ok, last_entry, timer_end, cfg_open;

  // x0 is never written, so its reset value of zero is what every read sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      shadow_q[wb_addr] <= wb_data;
    end
  end

  assign cfg_open = (state_q != StWait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_flag_q[i] <= '0;
        tbl_exp_q[i]  <= '0;
        tbl_reg_q[i]  <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      tbl_flag_q[cfg_idx] <= cfg_flag;
      tbl_exp_q[cfg_idx]  <= cfg_expected;
      tbl_reg_q[cfg_idx]  <= cfg_reg;
    end
  end

  assign cur_flag   = shadow_q[FlagAddr];
  assign cur_val    = shadow_q[tbl_reg_q[idx_q]];
  assign flag_hit   = (cur_flag == tbl_flag_q[idx_q]);
  assign val_ok     = (cur_val == tbl_exp_q[idx_q]);
  assign last_entry = ({1'b0, idx_q} == (count_q - (IdxW + 1)'(1)));
  assign timer_end  = (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    timer_d    = timer_q;
    fail_idx_d = fail_idx;
    fail_got_d = fail_got;
    case (state_q)
      StWait: begin
        if (timer_q != '1) timer_d = timer_q + TmrW'(1);
        // A flag match outranks the timeout in the same cycle.
        if (flag_hit) begin
          if (!val_ok) begin
            state_d    = StFail;
            fail_idx_d = idx_q;
            fail_got_d = cur_val;
          end else if (last_entry) begin
            state_d = StPass;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (timer_end) begin
          state_d = StTimeout;
        end
      end
      StIdle, StPass, StFail, StTimeout: begin
        if (start) begin
          count_d = cfg_count;
          idx_d   = '0;
          timer_d = '0;
          state_d = (cfg_count == '0) ? StPass : StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      fail_idx <= '0;
      fail_got <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      busy     <= (state_d == StWait);
      done     <= (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
      pass     <= (state_d == StPass);
      fail     <= (state_d == StFail);
      timeout  <= (state_d == StTimeout);
      fail_idx <= fail_idx_d;
      fail_got <= fail_got_d;
    end
  end

endmodule

// File: tb/tb_asm_check_monitor.sv
// Randomized and directed bench for asm_check_monitor against a behavioural
// model of the check table, shadow registers and run outcome.
module tb_asm_check_monitor;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NC   = 8;
  localparam int unsigned TO   = 100;
  localparam int unsigned FR   = 20;
  localparam int MIdle = 0, MWait = 1, MPass = 2, MFail = 3, MTimeout = 4;

  logic            clk, rst_n, wb_en, cfg_we, start;
  logic [4:0]      wb_addr, cfg_reg;
  logic [XLEN-1:0] wb_data, cfg_flag, cfg_expected;
  logic [2:0]      cfg_idx;
  logic [3:0]      cfg_count;
  logic            busy, done, pass, fail, timeout;
  logic [2:0]      fail_idx;
  logic [XLEN-1:0] fail_got;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [XLEN-1:0] m_sh [32];
  logic [XLEN-1:0] m_tf [NC];
  logic [XLEN-1:0] m_te [NC];
  logic [4:0]      m_tr [NC];
  int              m_st, m_idx, m_cnt, m_tmr, m_fidx;
  logic [XLEN-1:0] m_fgot;

  asm_check_monitor #(
    .XLEN(XLEN), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .FLAG_REG(FR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flag(cfg_flag), .cfg_reg(cfg_reg),
    .cfg_expected(cfg_expected), .cfg_count(cfg_count), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_got(fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] m_status();
    return {m_st == MWait, m_st >= MPass, m_st == MPass, m_st == MFail, m_st == MTimeout};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_sh[i] = '0;
    for (int i = 0; i < NC; i++) begin
      m_tf[i] = '0; m_te[i] = '0; m_tr[i] = '0;
    end
    m_st = MIdle; m_idx = 0; m_cnt = 0; m_tmr = 0; m_fidx = 0; m_fgot = '0;
  endtask

  // Applies one clock edge of the rules to the model, using pre-edge values.
  task automatic model_edge();
    int nst, nidx;
    nst = m_st; nidx = m_idx;
    if (m_st == MWait) begin
      if (m_sh[FR] == m_tf[m_idx]) begin
        if (m_sh[m_tr[m_idx]] != m_te[m_idx]) begin
          nst = MFail; m_fidx = m_idx; m_fgot = m_sh[m_tr[m_idx]];
        end else if (m_idx == m_cnt - 1) nst = MPass;
        else nidx = m_idx + 1;
      end else if (m_tmr == TO - 1) nst = MTimeout;
      m_tmr = m_tmr + 1;
    end else begin
      if (cfg_we) begin
        m_tf[cfg_idx] = cfg_flag; m_te[cfg_idx] = cfg_expected; m_tr[cfg_idx] = cfg_reg;
      end
      if (start) begin
        m_cnt = int'(cfg_count); nidx = 0; m_tmr = 0;
        nst = (cfg_count == 4'd0) ? MPass : MWait;
      end
    end
    if (wb_en && wb_addr != 5'd0) m_sh[wb_addr] = wb_data;
    m_st = nst; m_idx = nidx;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_addr = '0; wb_data = '0; cfg_we = 0; cfg_idx = '0; cfg_flag = '0;
    cfg_reg = '0; cfg_expected = '0; cfg_count = '0; start = 0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [XLEN-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  task automatic cfg_write(input int i, input int f, input int r, input int e);
    cfg_we = 1; cfg_idx = 3'(i); cfg_flag = XLEN'(f); cfg_reg = 5'(r); cfg_expected = XLEN'(e);
    tick();
    cfg_we = 0;
  endtask

  task automatic pulse_start(input int cnt);
    start = 1; cfg_count = 4'(cnt);
    tick();
    start = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic load_pass_table();
    cfg_write(0, 1, 1, 300);
    cfg_write(1, 2, 1, 500);
    cfg_write(2, 2, 2, 100);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b0 || fail_idx !== 3'd0 || fail_got !== '0) begin
      errors++;
      $display("FAIL reset_outputs got st=%b idx=%0d got=%0d want all zero",
               {busy, done, pass, fail, timeout}, fail_idx, fail_got);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    checks++;
    if ({busy, done, pass, fail, timeout} !== m_status()) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", {busy, done, pass, fail, timeout}, m_status());
    end
  endtask

  task automatic test_pass();
    load_pass_table();
    pulse_start(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pass_busy got %b want 1", busy);
    end
    wb_write(1, 300);
    wb_write(20, 1);
    wb_write(1, 500);
    wb_write(2, 100);
    wb_write(20, 2);
    tick();
    checks++;
    if (pass !== 1'b0 || busy !== 1'b1 || {busy, done, pass, fail, timeout} !== m_status()) begin
      errors++;
      $display("FAIL pass_first_flag2 got pass=%b busy=%b want pass=0 busy=1", pass, busy);
    end
    tick();
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b01100 || m_status() !== 5'b01100) begin
      errors++;
      $display("FAIL pass_final got %b model %b want 01100",
               {busy, done, pass, fail, timeout}, m_status());
    end
  endtask

  task automatic test_mismatch();
    pulse_start(3);
    wb_write(1, 299);
    wb_write(20, 1);
    tick();
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || fail_idx !== 3'd0 || fail_got !== 32'd299) begin
      errors++;
      $display("FAIL mismatch got fail=%b pass=%b idx=%0d val=%0d want 1 0 0 299",
               fail, pass, fail_idx, fail_got);
    end
    checks++;
    if ({busy, done, pass, fail, timeout} !== m_status() || fail_got !== m_fgot) begin
      errors++;
      $display("FAIL mismatch_model got %b want %b", {busy, done, pass, fail, timeout}, m_status());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_write(0, 1, 1, 300);
    pulse_start(1);
    for (int k = 1; k <= 100; k++) begin
      tick();
      checks++;
      if (timeout !== (k == 100) || busy !== (k != 100)) begin
        errors++;
        $display("FAIL timeout_cycle_%0d got timeout=%b busy=%b want %b %b",
                 k, timeout, busy, k == 100, k != 100);
      end
    end
    tick();
    tick();
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b01001 || m_status() !== 5'b01001) begin
      errors++;
      $display("FAIL timeout_hold got %b want 01001", {busy, done, pass, fail, timeout});
    end
  endtask

  task automatic test_edges();
    wb_write(0, 5);
    cfg_write(0, 0, 0, 0);
    pulse_start(1);
    tick();
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL x0_entry got pass=%b fail=%b want 1 0", pass, fail);
    end
    pulse_start(0);
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || m_status() !== 5'b01100) begin
      errors++; $display("FAIL count_zero got pass=%b busy=%b want 1 0", pass, busy);
    end
  endtask

  task automatic test_reset_midrun();
    load_pass_table();
    pulse_start(3);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrun_busy got %b want 1", busy);
    end
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL midrun_async got %b want 00000", {busy, done, pass, fail, timeout});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrun_idle got busy=%b done=%b want 0 0", busy, done);
    end
    load_pass_table();
    pulse_start(3);
    wb_write(1, 300);
    wb_write(20, 1);
    wb_write(1, 500);
    wb_write(2, 100);
    wb_write(20, 2);
    tick();
    tick();
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rerun got pass=%b fail=%b timeout=%b want 1 0 0", pass, fail, timeout);
    end
  endtask

  task automatic test_random();
    logic [4:0] pool [6];
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd20, 5'd20};
    for (int c = 0; c < 3000; c++) begin
      wb_en        = ($urandom % 2) == 0;
      wb_addr      = pool[$urandom % 6];
      wb_data      = XLEN'($urandom % 3);
      cfg_we       = ($urandom % 4) == 0;
      cfg_idx      = 3'($urandom % NC);
      cfg_flag     = XLEN'($urandom % 3);
      cfg_reg      = pool[$urandom % 4];
      cfg_expected = XLEN'($urandom % 3);
      cfg_count    = 4'($urandom % (NC + 1));
      start        = ($urandom % 24) == 0;
      tick();
      checks++;
      if ({busy, done, pass, fail, timeout} !== m_status() || fail_idx !== 3'(m_fidx) ||
          fail_got !== m_fgot) begin
        errors++;
        $display("FAIL random_cycle_%0d got st=%b idx=%0d val=%0d want st=%b idx=%0d val=%0d",
                 c, {busy, done, pass, fail, timeout}, fail_idx, fail_got,
                 m_status(), m_fidx, m_fgot);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_edges();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asm_check_monitor.md
ASM_CHECK_MONITOR -- requirements
Module: asm_check_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NUM_CHECKS, default 8, check-table depth.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100, maximum number of WAIT cycles before a timeout.
REQ-004 SHALL have parameter FLAG_REG, default 20, register index used as the progress flag.
REQ-005 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_en  in  1  register-file writeback valid.
- wb_addr  in  5  writeback destination register.
- wb_data  in  XLEN  writeback data.
- cfg_we  in  1  check-table write strobe.
- cfg_idx  in  clog2(NUM_CHECKS)  table entry index.
- cfg_flag  in  XLEN  flag value that triggers the entry.
- cfg_reg  in  5  register to check.
- cfg_expected  in  XLEN  expected register value.
- cfg_count  in  clog2(NUM_CHECKS)+1  number of active entries, sampled on start.
- start  in  1  one-cycle pulse that begins a run.
- busy  out  1  high in WAIT.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- timeout  out  1  high in TIMEOUT.
- fail_idx  out  clog2(NUM_CHECKS)  entry that mismatched.
- fail_got  out  XLEN  observed value at the mismatch.

Function
REQ-006 SHALL keep a 32-entry x XLEN shadow register file, written on the rising edge when wb_en=1 and wb_addr!=0; x0 SHALL always read 0.
REQ-007 All checks SHALL read the registered shadow values, so a writeback takes effect for comparison on the cycle after it is presented.
REQ-008 The check table SHALL be written on cfg_we=1 only in IDLE or a terminal state; cfg_we SHALL be ignored in WAIT.
REQ-009 The FSM SHALL have states IDLE, WAIT, PASS, FAIL and TIMEOUT.
REQ-010 On start in IDLE or a terminal state, the block SHALL latch cfg_count, clear the entry index and timer, and go to WAIT, or to PASS if cfg_count=0.
REQ-011 In WAIT, each cycle the block SHALL evaluate entry[idx]:
- If shadow[FLAG_REG]==flag and shadow[reg]==expected: on the last entry (idx==count-1), go to PASS; otherwise increment idx and stay in WAIT.
- If shadow[FLAG_REG]==flag and shadow[reg]!=expected: go to FAIL, and latch fail_idx=idx and fail_got=shadow[reg].
REQ-012 Only one entry SHALL be retired per cycle, so consecutive entries with the same flag retire on consecutive cycles.
REQ-013 The timer SHALL increment each WAIT cycle; when it reaches TIMEOUT_CYCLES-1 without a flag match, the FSM SHALL go to TIMEOUT.
REQ-014 A flag match SHALL take priority over timeout in the same cycle.
REQ-015 Terminal states SHALL hold until the next start or reset.
REQ-016 start SHALL be ignored in WAIT.
REQ-017 The shadow file SHALL NOT be cleared by start.
REQ-018 The timer SHALL be clog2(TIMEOUT_CYCLES)+1 bits wide and SHALL saturate, never wrapping.
REQ-019 All status outputs SHALL be registered and decoded from the state.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously clear:
- state to IDLE;
- the shadow file, check table, idx, timer and latched count;
- all outputs, including fail_idx and fail_got, to 0.
REQ-021 Deasserting rst_n mid-run SHALL leave the block in IDLE, with a new start required.

Verification
REQ-022 Pass case: table {flag=1, x1=300}, {flag=2, x1=500}, {flag=2, x2=100}; count=3; start; write x1=300, x20=1, then x1=500, x2=100, x20=2 -> pass=1 after the two flag-2 entries retire on consecutive cycles, with fail=0 and timeout=0.
REQ-023 Mismatch: same table with x1=299 written before x20=1 -> fail=1, fail_idx=0, fail_got=299, pass=0.
REQ-024 Timeout: TIMEOUT_CYCLES=100, start, x20 never written -> timeout=1 exactly 100 cycles after entering WAIT, with busy low afterward.
REQ-025 Edge cases:
- A write to x0=5 followed by an entry {flag=0, x0=0} -> that entry passes.
- count=0 -> pass on the cycle after start.
REQ-026 Reset mid-run: pull rst_n low during WAIT -> all outputs read 0 immediately, without waiting for a clock edge; after release, a fresh start with the REQ-022 stimulus passes again.
